// File: rtl/mac_operand_loader.sv
// Operand loader: issues reads for the address-generator stream and steers
// the returned words into a shared X buffer and per-MAC weight buffers.
module mac_operand_loader #(
  parameter int unsigned macCount  = 1,
  parameter int unsigned dataWidth = 16,
  parameter int unsigned xLen      = 64,
  parameter int unsigned yPerMac   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           adr,
  input  logic [macCount-1:0]  enables,
  input  logic                 adrDone,
  output logic [7:0]           memAdr,
  output logic                 memRd,
  input  logic [dataWidth-1:0] memData,
  input  logic [5:0]           xRdIdx,
  output logic [dataWidth-1:0] xRdData,
  input  logic [7:0]           wRdMac,
  input  logic [1:0]           wRdIdx,
  output logic [dataWidth-1:0] wRdData,
  output logic                 loadDone,
  output logic                 ovf
);

  typedef enum logic [2:0] {IDLE, LOAD_X, LOAD_W, DRAIN, DONE} state_e;

  localparam logic [6:0] XLEN7 = 7'(xLen);
  localparam logic [2:0] YMAX  = 3'(yPerMac);

  state_e              state_q, state_d;
  logic [6:0]          xCnt_q, xCnt_d;
  logic [2:0]          wCnt_q [macCount];
  logic [2:0]          wCnt_d [macCount];
  logic                ovf_q, ovf_d;
  logic                loadDone_q, loadDone_d;
  logic                tagVld_q, tagVld_d;
  logic                tagIsW_q, tagIsW_d;
  logic [5:0]          tagXIdx_q, tagXIdx_d;
  logic [macCount-1:0] tagMask_q, tagMask_d;
  logic [1:0]          tagWIdx_q [macCount];
  logic [1:0]          tagWIdx_d [macCount];
  logic                req, issue;

  logic [dataWidth-1:0] xBuf [64];
  logic [dataWidth-1:0] wBuf [macCount][4];

  always_comb begin
    req        = |enables;
    issue      = req && (state_q == IDLE || state_q == LOAD_X || state_q == LOAD_W);
    state_d    = state_q;
    xCnt_d     = xCnt_q;
    ovf_d      = ovf_q;
    tagVld_d   = 1'b0;
    tagIsW_d   = 1'b0;
    tagXIdx_d  = xCnt_q[5:0];
    tagMask_d  = '0;
    for (int unsigned m = 0; m < macCount; m++) begin
      wCnt_d[m]    = wCnt_q[m];
      tagWIdx_d[m] = wCnt_q[m][1:0];
    end

    case (state_q)
      // The first request in IDLE is already an X request.
      IDLE, LOAD_X: begin
        if (issue) begin
          tagVld_d = 1'b1;
          if (xCnt_q < XLEN7) xCnt_d = xCnt_q + 7'd1;
          state_d = (xCnt_q + 7'd1 >= XLEN7) ? LOAD_W : LOAD_X;
        end
        if (adrDone && (issue || state_q == LOAD_X)) begin
          ovf_d   = 1'b1;
          state_d = DRAIN;
        end
      end
      LOAD_W: begin
        if (issue) begin
          tagVld_d = 1'b1;
          tagIsW_d = 1'b1;
          for (int unsigned m = 0; m < macCount; m++) begin
            if (enables[m]) begin
              if (wCnt_q[m] == YMAX) begin
                ovf_d = 1'b1;
              end else begin
                tagMask_d[m] = 1'b1;
                wCnt_d[m]    = wCnt_q[m] + 3'd1;
              end
            end
          end
        end
        if (adrDone) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      DONE:    if (req) ovf_d = 1'b1;
      default: state_d = IDLE;
    endcase

    loadDone_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      xCnt_q     <= '0;
      ovf_q      <= 1'b0;
      loadDone_q <= 1'b0;
      tagVld_q   <= 1'b0;
      tagIsW_q   <= 1'b0;
      tagXIdx_q  <= '0;
      tagMask_q  <= '0;
      for (int unsigned m = 0; m < macCount; m++) begin
        wCnt_q[m]    <= '0;
        tagWIdx_q[m] <= '0;
      end
    end else begin
      state_q    <= state_d;
      xCnt_q     <= xCnt_d;
      ovf_q      <= ovf_d;
      loadDone_q <= loadDone_d;
      tagVld_q   <= tagVld_d;
      tagIsW_q   <= tagIsW_d;
      tagXIdx_q  <= tagXIdx_d;
      tagMask_q  <= tagMask_d;
      for (int unsigned m = 0; m < macCount; m++) begin
        wCnt_q[m]    <= wCnt_d[m];
        tagWIdx_q[m] <= tagWIdx_d[m];
      end
    end
  end

  // Buffers are plain storage; the return tag decides where memData lands.
  always_ff @(posedge clk) begin
    if (tagVld_q) begin
      if (!tagIsW_q) begin
        xBuf[tagXIdx_q] <= memData;
      end else begin
        for (int unsigned m = 0; m < macCount; m++) begin
          if (tagMask_q[m]) wBuf[m][tagWIdx_q[m]] <= memData;
        end
      end
    end
  end

  always_comb begin
    memRd   = rst && issue;
    memAdr  = memRd ? adr : '0;
    xRdData = xBuf[xRdIdx];
    wRdData = '0;
    for (int unsigned m = 0; m < macCount; m++) begin
      if (wRdMac == 8'(m)) wRdData = wBuf[m][wRdIdx];
    end
  end

  assign loadDone = loadDone_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
// Randomized bench for mac_operand_loader against a request-level reference model.
module tb_mac_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  adr = '0;
  logic [1:0]  enables = '0;
  logic        adrDone = 1'b0;
  logic [7:0]  memAdr;
  logic        memRd;
  logic [15:0] memData = '0;
  logic [5:0]  xRdIdx = '0;
  logic [15:0] xRdData;
  logic [7:0]  wRdMac = '0;
  logic [1:0]  wRdIdx = '0;
  logic [15:0] wRdData;
  logic        loadDone;
  logic        ovf;

  mac_operand_loader #(
    .macCount (2),
    .dataWidth(16),
    .xLen     (64),
    .yPerMac  (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .adr     (adr),
    .enables (enables),
    .adrDone (adrDone),
    .memAdr  (memAdr),
    .memRd   (memRd),
    .memData (memData),
    .xRdIdx  (xRdIdx),
    .xRdData (xRdData),
    .wRdMac  (wRdMac),
    .wRdIdx  (wRdIdx),
    .wRdData (wRdData),
    .loadDone(loadDone),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Synchronous memory: mem[a] = a + 0x100, garbage when not read.
  always @(posedge clk) memData <= memRd ? (16'(memAdr) + 16'h0100) : 16'($urandom);

  int checks = 0;
  int failures = 0;

  logic [15:0] mX [64];
  bit          mXv [64];
  logic [15:0] mW [2][4];
  bit          mWv [2][4];
  int          xc, wc0, wc1, doneCyc, cyc;
  bit          mOvf, started, fin;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    xc = 0; wc0 = 0; wc1 = 0; mOvf = 0; started = 0; fin = 0; doneCyc = 0;
  endtask

  task automatic model_w(input int m, input logic [15:0] d);
    int k;
    k = (m == 0) ? wc0 : wc1;
    if (k < 4) begin
      mW[m][k] = d; mWv[m][k] = 1;
      if (m == 0) wc0++; else wc1++;
    end else begin
      mOvf = 1;
    end
  endtask

  task automatic step(input logic [7:0] a, input logic [1:0] en, input bit dn);
    bit inX;
    @(negedge clk);
    adr = a; enables = en; adrDone = dn;
    #1;
    chk("memRd", memRd, !fin && en != 0);
    if (!fin && en != 0) chk("memAdr", memAdr, a);
    if (!fin) begin
      inX = (xc < 64);
      if (en != 0) begin
        started = 1;
        if (inX) begin
          mX[xc] = 16'h0100 + 16'(a); mXv[xc] = 1; xc++;
        end else begin
          if (en[0]) model_w(0, 16'h0100 + 16'(a));
          if (en[1]) model_w(1, 16'h0100 + 16'(a));
        end
      end
      if (dn && started) begin
        if (inX) mOvf = 1;
        fin = 1; doneCyc = cyc;
      end
    end else if (cyc >= doneCyc + 2 && en != 0) begin
      mOvf = 1;
    end
    @(posedge clk); #1;
    cyc++;
    chk("loadDone", loadDone, fin && cyc >= doneCyc + 2);
    chk("ovf", ovf, mOvf);
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b0; enables = 2'b11; adr = 8'h55; adrDone = 1'b0;
    #1;
    chk("rst_memRd", memRd, 0);
    chk("rst_memAdr", memAdr, 0);
    chk("rst_loadDone", loadDone, 0);
    chk("rst_ovf", ovf, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1; enables = '0;
  endtask

  task automatic chk_bufs();
    for (int i = 0; i < 64; i++) begin
      if (mXv[i]) begin
        xRdIdx = 6'(i); #1;
        chk($sformatf("xbuf[%0d]", i), xRdData, mX[i]);
      end
    end
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < 4; j++) begin
        if (mWv[m][j]) begin
          wRdMac = 8'(m); wRdIdx = 2'(j); #1;
          chk($sformatf("wbuf[%0d][%0d]", m, j), wRdData, mW[m][j]);
        end
      end
    end
    wRdMac = 8'd2; wRdIdx = 2'd1; #1;
    chk("wbuf_oob2", wRdData, 0);
    wRdMac = 8'hFF; #1;
    chk("wbuf_oobFF", wRdData, 0);
  endtask

  task automatic run_nominal(input bit gaps, input bit randEn);
    logic [1:0] en;
    for (int i = 0; i < 72; i++) begin
      if (gaps) begin
        while ($urandom_range(3) == 0) step(8'($urandom), 2'b00, 1'b0);
      end
      if (i < 64) en = randEn ? 2'($urandom_range(3, 1)) : 2'b11;
      else        en = (i < 68) ? 2'b01 : 2'b10;
      step(8'(i), en, i == 71);
    end
    repeat (3) step(8'($urandom), 2'b00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_reset();
    do_reset();

    // Nominal load
    run_nominal(1'b0, 1'b0);
    chk_bufs();
    xRdIdx = 6'd5; #1; chk("nom_x5", xRdData, 16'h0105);
    wRdMac = 8'd0; wRdIdx = 2'd0; #1; chk("nom_w00", wRdData, 16'h0140);
    wRdMac = 8'd1; wRdIdx = 2'd3; #1; chk("nom_w13", wRdData, 16'h0147);
    chk("nom_ovf", ovf, 0);

    // Request while DONE
    step(8'hAA, 2'b11, 1'b0);
    step(8'h00, 2'b00, 1'b0);
    chk("postdone_ovf", ovf, 1);
    chk_bufs();

    // Gapped, random broadcast enables
    do_reset();
    run_nominal(1'b1, 1'b1);
    chk_bufs();
    chk("gap_ovf", ovf, 0);

    // Weight overflow on MAC0
    do_reset();
    for (int i = 0; i < 64; i++) step(8'($urandom), 2'b11, 1'b0);
    for (int k = 0; k < 5; k++) step(8'(200 + k), 2'b01, k == 4);
    repeat (3) step(8'h00, 2'b00, 1'b0);
    chk_bufs();
    chk("wovf_ovf", ovf, 1);

    // Early adrDone after 10 X requests
    do_reset();
    for (int i = 0; i < 10; i++) step(8'($urandom), 2'($urandom_range(3, 1)), i == 9);
    repeat (3) step(8'h00, 2'b00, 1'b0);
    chk_bufs();
    chk("early_ovf", ovf, 1);

    // Reset mid-load, then a clean nominal load
    do_reset();
    for (int i = 0; i < 30; i++) step(8'($urandom), 2'b11, 1'b0);
    do_reset();
    run_nominal(1'b0, 1'b0);
    chk_bufs();
    chk("rerun_ovf", ovf, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_operand_loader.md
# mac_operand_loader

Downstream consumer of the MAC address-generator stage in the CNN datapath. Takes the per-cycle address/enable stream, issues reads to the synchronous operand memory, and steers returned words into local buffers:
- a shared 64-word input (X) buffer, broadcast to all MACs;
- a private 4-word weight (Y) buffer per MAC.

It asserts `loadDone` once every requested word has landed, so the MAC array can start computing.

## Interface
Parameters:
- `macCount`, default 1: number of MAC units, sized to match the address generator.
- `dataWidth`, default 16: memory word width.
- `xLen`, default 64: X words per load.
- `yPerMac`, default 4: weight words per MAC.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `adr`, in, 8: address from the generator.
- `enables`, in, `macCount`: per-MAC enables from the generator; any bit set means a valid request this cycle.
- `adrDone`, in, 1: generator finished; may be high in the same cycle as the final request.
- `memAdr`, out, 8: read address to memory.
- `memRd`, out, 1: read strobe; memory returns `memData` exactly one cycle later.
- `memData`, in, `dataWidth`: read data.
- `xRdIdx`, in, 6: X buffer read index.
- `xRdData`, out, `dataWidth`: X buffer word at `xRdIdx`; combinational read.
- `wRdMac`, in, 8: MAC select for weight read.
- `wRdIdx`, in, 2: weight index within the selected MAC.
- `wRdData`, out, `dataWidth`: weight word; combinational read.
- `loadDone`, out, 1: all words written.
- `ovf`, out, 1: sticky overflow/protocol error.

## Operation
States: IDLE, LOAD_X, LOAD_W, DRAIN, DONE.

- **Reset** (`rst`=0): state IDLE. `memRd`=0, `memAdr`=0, `loadDone`=0, `ovf`=0. All counters zero. Return-pipeline valid flag = 0. Buffer contents need not be cleared.
- **IDLE → LOAD_X** on the first cycle where `|enables`=1. That request is issued in the same cycle.
- **Issuing requests** (all load states):
  - `memRd` = `|enables`; `memAdr` = `adr`, passed through combinationally.
  - `memRd` is forced 0 in DRAIN and DONE.
- **Return tag:** each issued request captures a tag in a 1-deep return register: valid, phase (X/W), X index or enable vector.
- **LOAD_X:**
  - Each request takes X index = `xCnt`, then `xCnt`++.
  - After request number `xLen` is issued, go to LOAD_W.
- **LOAD_W:**
  - Each request writes to every MAC whose enable bit is set, at that MAC's own `wCnt[m]`; that `wCnt[m]` then increments.
  - A request whose target `wCnt[m]` = `yPerMac` is dropped for that MAC and sets `ovf`.
  - A request with `adrDone`=1 (request or not) moves to DRAIN.
- **DRAIN:** one cycle, letting the final return be written. Then go to DONE.
- **DONE:**
  - `loadDone`=1; further requests are ignored.
  - Stays in DONE until reset.
  - Any `|enables` in DONE sets `ovf`.
- **adrDone early:** `adrDone` asserted while in LOAD_X sets `ovf` and moves to DRAIN.
- **Data write:** one cycle after issue, `memData` is written to the location given by the tag.
- **Broadcast:** in the X phase, multiple enable bits still write a single shared X entry.
- **Width rules:**
  - `xCnt` is 7 bits, saturating at `xLen`.
  - `wCnt[m]` is 3 bits.
  - `wRdMac` ≥ `macCount` returns 0.

## Timing
- **Latency:**
  - Request at cycle t → memory returns at t+1 → buffer write at the t+1 rising edge.
  - The data is readable from cycle t+2.
- **`loadDone`:** rises 2 cycles after the cycle carrying `adrDone` (one DRAIN cycle, then DONE). It is a registered output.
- **Simultaneous events:** an X→W transition and a W request never share a cycle; the phase is decided by `xCnt` before the increment.
- **Bursts:** back-to-back requests every cycle are supported; there are no stalls and no backpressure.
- **Gaps:** cycles with `enables`=0 issue nothing and leave the counters unchanged.
- **Reset mid-load:** the asynchronous clear aborts at once. Any pending return is discarded, and the next load starts from IDLE.

## Test plan
- **Nominal** (`macCount`=2; memory returns `mem[a]`=a+0x100): adr 0..63 with enables=11, then 64..71 with one-hot enables, `adrDone` on adr 71.
  - X[i]=0x100+i.
  - W[0][0..3]=0x140..0x143; W[1][0..3]=0x144..0x147.
  - `loadDone` high 2 cycles after adr 71.
- **Gapped stream:** insert `enables`=0 idle cycles randomly into the nominal stream → identical buffer contents, `ovf`=0.
- **Weight overflow:** 5 requests to MAC0 → W[0][0..3] hold the first four returns, `ovf`=1, W[1] unchanged.
- **Early `adrDone`:** assert after 10 X requests → `ovf`=1, X[0..9] valid, `loadDone` 2 cycles later.
- **Reset mid-load:** pull `rst` low after 30 X requests, release, rerun nominal → outputs at reset values immediately, second load correct with `ovf`=0.
- **Post-done request:** request in DONE → `memRd`=0, `ovf`=1, buffers unchanged.
